// File: rtl/alu_8bit_core_if.sv
// alu_8bit_core_if: operand/result bus for the registered 8-bit ALU.
//   in_valid, a, b, cin, sel : request from the producer (operand fetch)
//   result, carry, out_valid : registered response to the consumer (writeback)
// master = side that issues operations, slave = the ALU.
interface alu_8bit_core_if;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [2:0]  sel;
    logic [15:0] result;
    logic        carry;
    logic        out_valid;

    modport master (
        output in_valid, a, b, cin, sel,
        input  result, carry, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin, sel,
        output result, carry, out_valid
    );
endinterface

// File: rtl/alu_8bit_core.sv
// alu_8bit_core: registered 8-bit ALU, one operation per clock, 1-cycle latency.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears result/carry/out_valid)
//   bus   : slave side of alu_8bit_core_if
//           sel 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 NOT, 111 zero
//           carry is carry-out for ADD, borrow-out for SUB, 0 otherwise.
module alu_8bit_core (
    input  logic         clk,
    input  logic         rst_n,
    alu_8bit_core_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_NOT = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        out_valid_q, out_valid_d;

    logic [8:0]  sum9;
    logic [8:0]  dif9;
    logic [15:0] prod;
    logic [15:0] calc_res;
    logic        calc_carry;

    // 9-bit add/sub: bit 8 is carry-out for ADD; for SUB the 9-bit
    // two's complement difference goes negative exactly when a < b + cin.
    assign sum9 = {1'b0, bus.a} + {1'b0, bus.b} + {8'h00, bus.cin};
    assign dif9 = {1'b0, bus.a} - {1'b0, bus.b} - {8'h00, bus.cin};
    assign prod = {8'h00, bus.a} * {8'h00, bus.b};

    always_comb begin
        calc_res   = 16'h0000;
        calc_carry = 1'b0;
        case (op_e'(bus.sel))
            OP_ADD: begin calc_res = {8'h00, sum9[7:0]}; calc_carry = sum9[8]; end
            OP_SUB: begin calc_res = {8'h00, dif9[7:0]}; calc_carry = dif9[8]; end
            OP_MUL: calc_res = prod;
            OP_AND: calc_res = {8'h00, bus.a & bus.b};
            OP_OR:  calc_res = {8'h00, bus.a | bus.b};
            OP_XOR: calc_res = {8'h00, bus.a ^ bus.b};
            OP_NOT: calc_res = {8'h00, ~bus.a};
            OP_RSV: calc_res = 16'h0000;
            default: calc_res = 16'h0000;
        endcase
    end

    // Idle cycles hold result/carry; only out_valid drops.
    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            result_d    = calc_res;
            carry_d     = calc_carry;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= 16'h0000;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_8bit_core.sv
// tb_alu_8bit_core: directed vector table, pipelining sequence and random
// regression against an arithmetic reference model of alu_8bit_core.
module tb_alu_8bit_core;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_8bit_core_if bus ();

    alu_8bit_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [15:0] exp_res;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[$];

    // Expected values in the model state
    logic [15:0] m_res;
    logic        m_carry;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference computed with plain integer arithmetic from the op rules.
    function automatic logic [16:0] ref_op(input logic [2:0] sel, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        int ia, ib, ic, r;
        logic c;
        ia = int'(a); ib = int'(b); ic = int'(cin);
        r = 0; c = 1'b0;
        case (sel)
            3'd0: begin r = (ia + ib + ic) % 256; c = (ia + ib + ic) > 255; end
            3'd1: begin r = (ia - ib - ic + 512) % 256; c = ia < (ib + ic); end
            3'd2: r = ia * ib;
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: r = 255 - ia;
            default: r = 0;
        endcase
        return {c, r[15:0]};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, sample at #1.
    task automatic step(input logic rst, input logic v, input logic [2:0] sel,
                        input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [16:0] r;
        rst_n = rst; bus.in_valid = v; bus.sel = sel; bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk);
        r = ref_op(sel, a, b, cin);
        if (!rst) begin
            m_res = 16'h0; m_carry = 1'b0; m_valid = 1'b0;
        end else if (v) begin
            m_res = r[15:0]; m_carry = r[16]; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, ".result"}, 32'(bus.result), 32'(m_res));
        chk({name, ".carry"}, 32'(bus.carry), 32'(m_carry));
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    endtask

    initial begin
        logic [15:0] held_res;
        logic        held_carry;
        checks = 0; errors = 0;
        m_res = 16'h0; m_carry = 1'b0; m_valid = 1'b0;
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.a = 8'h0; bus.b = 8'h0; bus.cin = 1'b0; bus.sel = 3'd0;

        vecs.push_back('{"add_1_0",     3'd0, 8'h01, 8'h00, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{"add_ff_01",   3'd0, 8'hFF, 8'h01, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"add_ff_00_c", 3'd0, 8'hFF, 8'h00, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{"sub_1_0",     3'd1, 8'h01, 8'h00, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{"sub_0_1",     3'd1, 8'h00, 8'h01, 1'b0, 16'h00FF, 1'b1});
        vecs.push_back('{"sub_0_0_b",   3'd1, 8'h00, 8'h00, 1'b1, 16'h00FF, 1'b1});
        vecs.push_back('{"sub_5_4_b",   3'd1, 8'h05, 8'h04, 1'b1, 16'h0000, 1'b0});
        vecs.push_back('{"mul_3_3",     3'd2, 8'h03, 8'h03, 1'b1, 16'h0009, 1'b0});
        vecs.push_back('{"mul_ff_ff",   3'd2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0});
        vecs.push_back('{"mul_80_02",   3'd2, 8'h80, 8'h02, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{"and_1_1",     3'd3, 8'h01, 8'h01, 1'b1, 16'h0001, 1'b0});
        vecs.push_back('{"or_1_0",      3'd4, 8'h01, 8'h00, 1'b1, 16'h0001, 1'b0});
        vecs.push_back('{"xor_1_1",     3'd5, 8'h01, 8'h01, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"not_1",       3'd6, 8'h01, 8'hA5, 1'b1, 16'h00FE, 1'b0});
        vecs.push_back('{"rsv",         3'd7, 8'hFF, 8'hFF, 1'b1, 16'h0000, 1'b0});

        // Reset held with valid traffic present
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            chk("rst.result", 32'(bus.result), 32'h0);
            chk("rst.carry", 32'(bus.carry), 32'h0);
            chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
        end
        step(1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 1'b0);
        chk("idle_after_rst.result", 32'(bus.result), 32'h0);
        chk("idle_after_rst.out_valid", 32'(bus.out_valid), 32'h0);

        // Directed table: each op issued alone, output checked one cycle later
        foreach (vecs[i]) begin
            step(1'b1, 1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
            chk({vecs[i].name, ".result"}, 32'(bus.result), 32'(vecs[i].exp_res));
            chk({vecs[i].name, ".carry"}, 32'(bus.carry), 32'(vecs[i].exp_carry));
            chk({vecs[i].name, ".out_valid"}, 32'(bus.out_valid), 32'h1);
            step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            chk({vecs[i].name, ".hold"}, 32'(bus.result), 32'(vecs[i].exp_res));
            chk({vecs[i].name, ".gap_valid"}, 32'(bus.out_valid), 32'h0);
        end

        // Back-to-back ADD, MUL, NOT then a gap
        step(1'b1, 1'b1, 3'd0, 8'h10, 8'h20, 1'b1);
        chk("pipe_add", 32'({bus.out_valid, bus.carry, bus.result}), {15'h0, 1'b1, 1'b0, 16'h0031});
        step(1'b1, 1'b1, 3'd2, 8'h12, 8'h34, 1'b0);
        chk("pipe_mul", 32'({bus.out_valid, bus.carry, bus.result}), {15'h0, 1'b1, 1'b0, 16'h03A8});
        step(1'b1, 1'b1, 3'd6, 8'h3C, 8'h00, 1'b0);
        chk("pipe_not", 32'({bus.out_valid, bus.carry, bus.result}), {15'h0, 1'b1, 1'b0, 16'h00C3});
        step(1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 1'b1);
        chk("pipe_gap", 32'({bus.out_valid, bus.carry, bus.result}), {15'h0, 1'b0, 1'b0, 16'h00C3});

        // Inputs changing between edges must not disturb registered outputs
        step(1'b1, 1'b1, 3'd0, 8'hFF, 8'h01, 1'b0);
        held_res = bus.result; held_carry = bus.carry;
        bus.sel = 3'd2; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
        #3;
        chk("mid_cycle.result", 32'(bus.result), 32'h0000);
        chk("mid_cycle.carry", 32'(bus.carry), 32'h1);

        // Reset on the same edge as a valid op discards it
        step(1'b0, 1'b1, 3'd2, 8'hFF, 8'hFF, 1'b0);
        chk("rst_discard", 32'({bus.out_valid, bus.carry, bus.result}), 32'h0);
        step(1'b1, 1'b1, 3'd2, 8'h02, 8'h03, 1'b0);
        chk("post_rst_first", 32'({bus.out_valid, bus.carry, bus.result}), {15'h0, 1'b1, 1'b0, 16'h0006});

        // Random regression with occasional reset pulses
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), 3'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_8bit_core.md
# alu_8bit_core

Registered 8-bit arithmetic/logic unit. It takes two 8-bit operands, a carry/borrow input and a 3-bit operation select. It produces a 16-bit result plus a carry/borrow flag, both registered with one-cycle latency. It serves as the datapath execute stage, between operand fetch and writeback, and is fed one operation per clock.

## Interface
Parameters: none; all widths are fixed.

- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  operands and sel are valid this cycle
- a  input  8  operand A, unsigned
- b  input  8  operand B, unsigned
- cin  input  1  carry-in for ADD, borrow-in for SUB; ignored by other ops
- sel  input  3  operation select
- result  output  16  registered result
- carry  output  1  registered carry-out (ADD) or borrow-out (SUB); 0 otherwise
- out_valid  output  1  result/carry correspond to an accepted in_valid operation

## Operation
The operation is chosen by sel. All arithmetic is unsigned.

- 000 ADD: s = a + b + cin, 9 bits wide; result = {8'h00, s[7:0]}; carry = s[8].
- 001 SUB: d = a − b − cin, 9-bit two's complement; result = {8'h00, d[7:0]}; carry = 1 iff a < b + cin (borrow).
- 010 MUL: result = a × b, full 16-bit product with no truncation; carry = 0.
- 011 AND: result = {8'h00, a & b}; carry = 0.
- 100 OR: result = {8'h00, a | b}; carry = 0.
- 101 XOR: result = {8'h00, a ^ b}; carry = 0.
- 110 NOT: result = {8'h00, ~a}; b and cin are ignored; carry = 0.
- 111 reserved: result = 16'h0000; carry = 0.

General rules:
- Upper byte of result is 0 for every op except MUL.
- cin affects only ADD and SUB.
- The compute logic is purely combinational from the inputs; only the output registers hold state.

## Timing
- Reset: when rst_n = 0 at a rising edge, the next values are result = 16'h0000, carry = 0, out_valid = 0. Reset takes priority over in_valid.
- Accepted operation: when rst_n = 1 and in_valid = 1 at edge N, result and carry take the computed values of a, b, cin, sel sampled at edge N. out_valid = 1 after edge N. Latency is exactly 1 cycle.
- Idle cycle: when in_valid = 0 at edge N, result and carry hold their previous values and out_valid = 0 after edge N.
- Throughput: one operation per cycle. Back-to-back in_valid cycles each produce a new output one cycle later. There are no stalls and no backpressure.
- Input changes between edges have no effect on the outputs.
- Reset mid-stream: an operation accepted at the same edge where rst_n = 0 is discarded. The first valid output appears one cycle after the first accepted in_valid following reset release.
- Boundary cases:
  - ADD 8'hFF + 8'h00 + 1 gives result 16'h0000, carry 1.
  - SUB 8'h00 − 8'h00 − 1 gives result 16'h00FF, carry 1.
  - MUL 8'hFF × 8'hFF gives 16'hFE01.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 and random inputs -> result = 16'h0000, carry = 0, out_valid = 0. Release reset, then apply in_valid = 0 -> outputs hold and out_valid stays 0.
- Arithmetic:
  - ADD a = 1, b = 0, cin = 0 -> 16'h0001, carry 0.
  - ADD a = 8'hFF, b = 8'h01, cin = 0 -> 16'h0000, carry 1.
  - SUB a = 1, b = 0, cin = 0 -> 16'h0001, carry 0.
  - SUB a = 0, b = 1, cin = 0 -> 16'h00FF, carry 1.
- Multiply:
  - a = 3, b = 3 -> 16'h0009, carry 0.
  - a = 8'hFF, b = 8'hFF -> 16'hFE01.
  - a = 8'h80, b = 8'h02 -> 16'h0100.
- Logic, each with out_valid = 1 one cycle after the inputs:
  - AND a = 1, b = 1 -> 16'h0001.
  - OR a = 1, b = 0 -> 16'h0001.
  - XOR a = 1, b = 1 -> 16'h0000.
  - NOT a = 1 -> 16'h00FE.
  - sel = 111 -> 16'h0000.
- Pipelining: issue ADD, MUL, NOT on consecutive cycles -> their outputs appear on the three consecutive following cycles in the same order. A gap in in_valid gives out_valid = 0 for that cycle, with result held.
- Random regression: at least 10k random a, b, cin, sel with random in_valid and occasional rst_n pulses, compared against a reference model with 1-cycle latency.
